// File: rtl/mat_vec_engine.sv
// Systolic matrix-vector multiplier: C[r] = sum_k A[r][k]*B[k].
// Row lanes are skewed one cycle per row; results are held until the consumer takes them.
module mat_vec_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int MAX_K      = 256,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_K+1)-1:0]    vec_len,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_col,
  input  logic [DATA_WIDTH-1:0]         b_elem,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*ACC_WIDTH-1:0]     c_out,
  output logic                          overflow,
  output logic                          busy
);

  localparam int LW  = $clog2(MAX_K+1);
  localparam int CW  = $clog2(ROWS+1);
  localparam int DW2 = 2*DATA_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_cnt;
  logic [CW-1:0] drain_cnt;
  logic          kill;
  logic          go;
  logic          accept;
  logic          last_beat;
  logic          drain_end;

  logic [ROWS-1:0]       en_pipe;
  logic [DATA_WIDTH-1:0] b_pipe [ROWS];
  logic [ROWS-1:0]       lane_ovf;

  assign kill      = abort && (state != IDLE);
  assign go        = start && (state == IDLE);
  assign accept    = (state == RUN) && in_valid && !abort;
  assign last_beat = accept && ((beat_cnt + LW'(1)) == len_q);
  assign drain_end = (state == DRAIN) && (drain_cnt == CW'(ROWS));

  assign in_ready  = (state == RUN) && !abort;
  assign out_valid = (state == DONE) && !abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else if (kill) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= vec_len;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            state     <= (vec_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + LW'(1);
            if (last_beat)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_end)
            state <= DONE;
          else
            drain_cnt <= drain_cnt + CW'(1);
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enable and B travel down the skew; row r taps stage r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
      for (int i = 0; i < ROWS; i++)
        b_pipe[i] <= '0;
    end else begin
      en_pipe[0] <= accept;
      b_pipe[0]  <= b_elem;
      for (int i = 1; i < ROWS; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        b_pipe[i]  <= b_pipe[i-1];
      end
      if (kill)
        en_pipe <= '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] a_sh [0:r];
    logic [DW2-1:0]        prod;
    logic [ACC_WIDTH-1:0]  addend;
    logic [ACC_WIDTH:0]    sum;
    logic [ACC_WIDTH-1:0]  sat_val;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_nxt;
    logic                  ovf;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++)
          a_sh[i] <= '0;
      end else begin
        a_sh[0] <= a_col[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++)
          a_sh[i] <= a_sh[i-1];
      end
    end

    always_comb begin
      prod    = '0;
      addend  = '0;
      sat_val = '1;
      ovf     = 1'b0;
      if (SIGNED != 0) begin
        prod   = DW2'($signed(a_sh[r])) * DW2'($signed(b_pipe[r]));
        addend = ACC_WIDTH'($signed(prod));
      end else begin
        prod   = DW2'(a_sh[r]) * DW2'(b_pipe[r]);
        addend = ACC_WIDTH'(prod);
      end
      sum = {1'b0, acc} + {1'b0, addend};
      if (SIGNED != 0) begin
        ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        sat_val = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        ovf = sum[ACC_WIDTH];
      end
      acc_nxt = ((SATURATE != 0) && ovf) ? sat_val : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        acc <= '0;
      else if (go)
        acc <= '0;
      else if (en_pipe[r] && !kill)
        acc <= acc_nxt;
    end

    assign c_out[r*ACC_WIDTH +: ACC_WIDTH] = acc;
    assign lane_ovf[r] = en_pipe[r] && ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (go)
      overflow <= 1'b0;
    else if (!kill && (|lane_ovf))
      overflow <= 1'b1;
  end

endmodule

// File: doc/mat_vec_engine.md
Name: mat_vec_engine

Overview:
- Parametrised systolic matrix-vector multiplier computing C[r] = sum over k of A[r][k]*B[k], for r = 0..ROWS-1 and k = 0..vec_len-1.
- Input is a stream of beats. Each beat carries one column of A (one element per row) plus the matching B element.
- Row lanes are skewed internally: row r processes a beat r cycles after row 0.
- Adds valid/ready handshakes, a programmable vector length, signed/unsigned arithmetic, optional saturation, abort, and automatic completion. It sits between the operand-fetch logic and the result writeback path.

Parameters:
- DATA_WIDTH, 8, width of each A and B element
- ROWS, 8, number of MAC lanes (rows of A, elements of C)
- MAX_K, 256, maximum vector length; the length counter is clog2(MAX_K+1) bits wide
- ACC_WIDTH, 3*DATA_WIDTH, accumulator and result width per row
- SIGNED, 0, 1 = two's-complement operands and accumulation; 0 = unsigned
- SATURATE, 0, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-high reset
- start, input, 1, one-cycle pulse that begins a job; honoured only in IDLE
- vec_len, input, clog2(MAX_K+1), number of beats in the job; sampled when start is honoured
- abort, input, 1, cancels the job in progress
- in_valid, input, 1, beat valid
- in_ready, output, 1, engine accepts a beat
- a_col, input, ROWS*DATA_WIDTH, column of A; row r occupies bits [r*DATA_WIDTH +: DATA_WIDTH]
- b_elem, input, DATA_WIDTH, B element for this beat
- out_valid, output, 1, c_out holds the final results
- out_ready, input, 1, consumer accepts the results
- c_out, output, ROWS*ACC_WIDTH, results; row r occupies bits [r*ACC_WIDTH +: ACC_WIDTH]
- overflow, output, 1, sticky flag: any lane overflowed during the job
- busy, output, 1, state is not IDLE

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all accumulators, skew registers and counters cleared. Outputs: in_ready=0, out_valid=0, c_out=0, overflow=0, busy=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - latch vec_len;
  - clear accumulators and overflow;
  - vec_len=0: go to DONE (c_out all zero);
  - otherwise go to RUN.
- RUN:
  - in_ready=1;
  - a beat is accepted on in_valid & in_ready and increments the beat counter;
  - when the vec_len-th beat is accepted, go to DRAIN with in_ready=0 from the next cycle;
  - cycles with in_valid=0 inject a bubble (enable=0) that travels through the skew alongside the data.
- Datapath: an accepted beat is registered in stage 0 together with its enable bit. B, its enable bit, and the A element for row r are delayed r further cycles. Row r's accumulator adds A[r]*B on the edge after its aligned enable is seen. The beat accepted at edge E therefore lands in row r's accumulator at edge E+1+r.
- DRAIN: counts ROWS cycles, then goes to DONE. out_valid rises exactly ROWS+1 cycles after the edge that accepted the last beat.
- DONE:
  - out_valid=1 and c_out held stable while out_ready=0;
  - out_valid & out_ready returns the engine to IDLE;
  - c_out keeps its value until the next start.
- Arithmetic:
  - the product is 2*DATA_WIDTH bits, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH before the add;
  - an overflow is a signed carry mismatch (SIGNED=1) or a carry out of the top bit (SIGNED=0);
  - SATURATE=1: the accumulator clamps to max/min and stays clamped, re-clamping on later overflows;
  - SATURATE=0: the accumulator wraps;
  - overflow is set in both modes.
- abort (any non-IDLE state): next state IDLE; skew enables cleared; accumulators left as-is; out_valid=0. abort has priority over start and over the handshakes in the same cycle. abort in IDLE is ignored.
- start outside IDLE is ignored. A start in the same cycle as the out_valid & out_ready handshake is also ignored; the engine enters IDLE first.
- Asserting rst mid-job behaves as full reset; no partial result is presented.

Test Plan:
- ROWS=4, DATA_WIDTH=8, SIGNED=0: vec_len=3, columns (1,4,7,10),(2,5,8,11),(3,6,9,12), B=1,1,2, in_valid held high -> out_valid rises 5 cycles after the third accept; c_out = 9,21,33,45; overflow=0.
- Same data with in_valid low for 2 cycles between each beat, and out_ready held low 10 cycles -> c_out = 9,21,33,45; out_valid and c_out stable through the stall; busy=0 after the handshake.
- SIGNED=1, vec_len=1, all a=0xFD (-3), b=5 -> every lane 0xFFFFF1 (-15, 24 bits).
- SIGNED=1, SATURATE=1, ACC_WIDTH=16, vec_len=5, all a=b=127 -> every lane 0x7FFF; overflow=1. Repeat with SATURATE=0 -> every lane 0x3B05 (80645 mod 65536 = 15109, no sign issue); overflow=1.
- vec_len=0 start -> out_valid the cycle after start, c_out=0. Then start with vec_len=3 and abort after 2 beats -> IDLE, out_valid never asserted. A following full job gives correct results.
- rst pulsed during DRAIN -> all outputs zero immediately (asynchronous). A new job afterwards produces 9,21,33,45.
